score_event_sched: RTL

Schedules hit-grade events from several independent requesters (lane/player hit detectors) onto the single 2-bit `Inp` port of the score counter, which accepts at most one event per clock. Each requester has a small FIFO, and a round-robin arbiter drains one event per cycle. The block also provides pause and clear control. It sits between the hit detectors and the score counter. It drives the counter's `Inp` and generates the counter's clear pulse.

---
 rtl/score_pkg.sv | 22 ++
 rtl/hit_fifo.sv | 60 ++++++
 rtl/score_event_sched.sv | 116 +++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// Grade encoding and score constants shared by the event scheduler and the score counter.
package score_pkg;

   typedef logic [1:0] grade_t;

   localparam grade_t GRADE_NONE = 2'b00;
   localparam grade_t GRADE_01   = 2'b01;
   localparam grade_t GRADE_10   = 2'b10;
   localparam grade_t GRADE_11   = 2'b11;

   localparam int unsigned WEIGHT_01 = 32;
   localparam int unsigned WEIGHT_10 = 256;
   localparam int unsigned WEIGHT_11 = 512;
   localparam int unsigned MAX_SCORE = 65535;

   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == CNT_MAX) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/hit_fifo.sv
// Per-requester grade FIFO; pointers carry an extra wrap bit so full and empty are distinct.
// Flush has priority over push and pop. Pushing when full or popping when empty is ignored.
module hit_fifo
   import score_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       flush,
   input  logic       push,
   input  logic [1:0] din,
   input  logic       pop,
   output logic [1:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [AW:0] wr_q, wr_d;
   logic [AW:0] rd_q, rd_d;
   grade_t      mem_q [FIFO_DEPTH];
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign dout    = mem_q[rd_q[AW-1:0]];
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (flush) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + 1'b1;
         if (do_pop)  rd_d = rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage needs no reset: contents are only visible through the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/score_event_sched.sv
// Round-robin scheduler of per-requester hit grades onto the score counter's single Inp port.
// Two-cycle push-to-output latency; freeze stalls issue, clear flushes state and pulses score_clr.
module score_event_sched
   import score_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [2*N_REQ-1:0]   req_grade,
   output logic [N_REQ-1:0]     req_ready,
   input  logic                 freeze,
   input  logic                 clear,
   output logic [1:0]           score_inp,
   output logic                 score_clr,
   output logic                 busy,
   output logic [15:0]          issued_cnt
);

   localparam int PW = $clog2(N_REQ);

   logic [N_REQ-1:0] full;
   logic [N_REQ-1:0] empty;
   logic [N_REQ-1:0] push;
   logic [N_REQ-1:0] pop;
   logic [1:0]       dout [N_REQ];

   logic [PW-1:0] rr_q, rr_d;
   grade_t        inp_q, inp_d;
   logic          clr_q, clr_d;
   logic [15:0]   cnt_q, cnt_d;

   logic          hit_vld;
   logic [PW-1:0] hit_idx;
   logic          gnt_vld;

   // Ready comes from registered occupancy only; a popping full FIFO still refuses.
   assign req_ready = ~full & {N_REQ{~clear}};

   for (genvar g = 0; g < N_REQ; g++) begin : g_req
      assign push[g] = req_valid[g] && req_ready[g]
                       && (req_grade[2*g +: 2] != GRADE_NONE);

      hit_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
         .clk   (clk),
         .reset (reset),
         .flush (clear),
         .push  (push[g]),
         .din   (req_grade[2*g +: 2]),
         .pop   (pop[g]),
         .dout  (dout[g]),
         .full  (full[g]),
         .empty (empty[g])
      );
   end

   // Scan downward so the candidate nearest rr_q is the last to be written.
   always_comb begin
      int idx;
      idx     = 0;
      hit_vld = 1'b0;
      hit_idx = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = (int'(rr_q) + k) % N_REQ;
         if (!empty[idx]) begin
            hit_vld = 1'b1;
            hit_idx = idx[PW-1:0];
         end
      end
   end

   assign gnt_vld = hit_vld && !freeze && !clear;

   always_comb begin
      pop = '0;
      if (gnt_vld) pop[hit_idx] = 1'b1;
   end

   always_comb begin
      rr_d  = rr_q;
      inp_d = GRADE_NONE;
      clr_d = 1'b0;
      cnt_d = cnt_q;
      if (clear) begin
         rr_d  = '0;
         cnt_d = '0;
         clr_d = 1'b1;
      end else if (gnt_vld) begin
         inp_d = dout[hit_idx];
         cnt_d = sat_inc(cnt_q);
         rr_d  = (hit_idx == PW'(N_REQ - 1)) ? '0 : hit_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rr_q  <= '0;
         inp_q <= GRADE_NONE;
         clr_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         rr_q  <= rr_d;
         inp_q <= inp_d;
         clr_q <= clr_d;
         cnt_q <= cnt_d;
      end
   end

   assign score_inp  = inp_q;
   assign score_clr  = clr_q;
   assign issued_cnt = cnt_q;
   assign busy       = |(~empty);

endmodule
